usb_resp_tx: RTL and testbench
==============================

Name: usb_resp_tx

Overview:
- Upstream response framer for the FX2 slave-FIFO link; the transmit counterpart of the downstream command parser.
- On a trigger pulse, it snapshots a command echo, a 32-bit register value and a status word.
- It builds a fixed-length response packet, requests the FX2 upload port and streams the packet out one 16-bit word per grant.
- It sits beside the IQ stream source on the fx2 up_req/up_grant/up_dat/up_fin port; the upper-level mux routes the port to it.

Parameters:
PKT_WORDS, 256, packet length in 16-bit words (must equal the FX2 upload packet size, >=8)
SYNC_WORD, 16'hA55A, header word 0 (pre-swap value)

Ports:
clk_24m  input  1  system clock, same clock as fx2
rst_n  input  1  asynchronous active-low reset
trig  input  1  one-cycle request to send a response
trig_cmd  input  16  command word to echo
trig_val  input  32  register value to report (e.g. reg_freq)
status  input  16  status word, sampled with trig
busy  output  1  high from accepted trig until the packet finishes or aborts
up_req  output  1  upload request to fx2
up_grant  input  1  fx2 consumed current up_dat this cycle
up_dat  output  16  current word, prefetched (valid before grant)
up_fin  input  1  fx2 reports packet committed
seq  output  16  sequence number of the next packet
drop_cnt  output  8  triggers ignored while busy, saturating at 255
abort_cnt  output  8  packets ended by early up_fin, saturating at 255

Behaviour:
- Reset (async, rst_n low) forces all outputs to 0: busy=0, up_req=0, up_dat=0, seq=0, drop_cnt=0, abort_cnt=0, state=IDLE, idx=0. The snapshot registers also clear.
- Packet words, pre-swap:
  - w0 = SYNC_WORD
  - w1 = cmd
  - w2 = val[31:16]
  - w3 = val[15:0]
  - w4 = status
  - w5 = seq value at trigger time
  - w6 = ~(16-bit sum of w0..w5, mod 2^16)
  - w7..w(PKT_WORDS-1) = 16'h0000
- Byte swap: the bus word is {w[7:0], w[15:8]}, matching the downstream parser's byte order.
- Checksum: computed in IDLE->ARM transition pipeline. It must be valid before the first grant.
- States:
  - IDLE: busy=0, up_req=0. On trig, latch cmd/val/status/seq, idx<=0, busy<=1, go ARM next cycle. up_req rises 1 cycle after trig (latency 1).
  - ARM/SEND (up_req=1): up_dat = swapped w[idx] at all times. Each cycle with up_grant=1: if idx < PKT_WORDS-1 then idx<=idx+1; on grant with idx==PKT_WORDS-1, go WAIT_FIN. Grants arriving in WAIT_FIN are ignored and up_dat holds 0.
  - WAIT_FIN: up_req stays 1 until up_fin. On up_fin: up_req<=0, busy<=0, seq<=seq+1 (wrap 16'hFFFF->0), go IDLE.
- Early up_fin (in ARM/SEND, before the last word is granted): abort. up_req<=0, busy<=0, abort_cnt++ (saturating), seq still increments, go IDLE.
- up_grant and up_fin in the same cycle: the grant is counted first, then the fin is evaluated. The packet counts as complete only if that grant was the last word.
- trig while busy: ignored, drop_cnt++ (saturating), snapshot unchanged.
- trig in the same cycle as the completing up_fin: the trigger is dropped (busy still 1 that cycle).
- up_grant while up_req=0: ignored.
- rst_n low mid-packet: immediate return to the reset values above. No partial state survives.

Test Plan:
- Basic frame: trig with cmd=16'h0002, val=32'h01234567, status=16'h00FF, seq=0 -> up_req high the next cycle. Granted words are 5AA5, 0200, 2301, 6745, FF00, 0000, 1A13, then 249 words of 0000. up_fin -> up_req=0, busy=0, seq=1.
- Throttled grants: grants every third cycle plus random gaps -> identical word sequence. idx never advances without a grant. up_req is held through the gaps.
- Early fin: up_fin after 10 grants -> up_req=0 next cycle, abort_cnt=1, seq=1. A new trig then sends a fresh packet with w5 = 0001.
- Busy trigger: trig during SEND with different data, three times -> drop_cnt=3. The packet in flight is unchanged.
- Simultaneous and wrap cases:
  - Last grant and up_fin in the same cycle -> clean completion, abort_cnt unchanged.
  - Preload seq to 16'hFFFF via repeated packets -> the next seq is 0000.
- Reset mid-SEND: rst_n low at word 100 -> all outputs 0 immediately. After release, trig sends a full packet starting at 5AA5.

Source files
------------

// File: rtl/usb_resp_tx_if.sv
// FX2 upload port bundle: request/data from the framer, grant/fin from the FX2 side.
interface usb_resp_tx_if;
    logic        up_req;
    logic        up_grant;
    logic [15:0] up_dat;
    logic        up_fin;

    modport master (
        output up_req,
        output up_dat,
        input  up_grant,
        input  up_fin
    );

    modport slave (
        input  up_req,
        input  up_dat,
        output up_grant,
        output up_fin
    );
endinterface

// File: rtl/usb_resp_tx.sv
// Upstream response framer: snapshots a command echo, register value and status on
// trig, then streams a fixed-length byte-swapped packet to the FX2 upload port.
module usb_resp_tx #(
    parameter int unsigned PKT_WORDS = 256,
    parameter logic [15:0] SYNC_WORD = 16'hA55A
) (
    input  logic        clk_24m,
    input  logic        rst_n,
    input  logic        trig,
    input  logic [15:0] trig_cmd,
    input  logic [31:0] trig_val,
    input  logic [15:0] status,
    output logic        busy,
    output logic [15:0] seq,
    output logic [7:0]  drop_cnt,
    output logic [7:0]  abort_cnt,
    usb_resp_tx_if.master up
);

    localparam int unsigned IDX_W = $clog2(PKT_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARM      = 2'd1,
        SEND     = 2'd2,
        WAIT_FIN = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             req_q, req_d;
    logic [15:0]      dat_q, dat_d;
    logic [15:0]      seq_q, seq_d;
    logic [7:0]       drop_q, drop_d;
    logic [7:0]       abort_q, abort_d;
    logic [15:0]      cmd_q, cmd_d;
    logic [31:0]      val_q, val_d;
    logic [15:0]      stat_q, stat_d;
    logic [15:0]      sseq_q, sseq_d;
    logic [15:0]      chk_q, chk_d;
    logic             last_grant;

    // Bus byte order expected by the downstream parser.
    function automatic logic [15:0] swap16(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

    // Pre-swap packet word at a given index; tail words are zero.
    function automatic logic [15:0] pkt_word(
        input logic [IDX_W-1:0] i,
        input logic [15:0]      c,
        input logic [31:0]      v,
        input logic [15:0]      st,
        input logic [15:0]      sq,
        input logic [15:0]      ck
    );
        logic [15:0] w;
        w = 16'h0000;
        case (i)
            IDX_W'(0): w = SYNC_WORD;
            IDX_W'(1): w = c;
            IDX_W'(2): w = v[31:16];
            IDX_W'(3): w = v[15:0];
            IDX_W'(4): w = st;
            IDX_W'(5): w = sq;
            IDX_W'(6): w = ck;
            default:   w = 16'h0000;
        endcase
        return w;
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            req_q   <= 1'b0;
            dat_q   <= 16'h0000;
            seq_q   <= 16'h0000;
            drop_q  <= 8'h00;
            abort_q <= 8'h00;
            cmd_q   <= 16'h0000;
            val_q   <= 32'h0000_0000;
            stat_q  <= 16'h0000;
            sseq_q  <= 16'h0000;
            chk_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            req_q   <= req_d;
            dat_q   <= dat_d;
            seq_q   <= seq_d;
            drop_q  <= drop_d;
            abort_q <= abort_d;
            cmd_q   <= cmd_d;
            val_q   <= val_d;
            stat_q  <= stat_d;
            sseq_q  <= sseq_d;
            chk_q   <= chk_d;
        end
    end

    // Next-state logic: grant is applied before fin so a same-cycle last grant completes cleanly.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        busy_d     = busy_q;
        req_d      = req_q;
        dat_d      = dat_q;
        seq_d      = seq_q;
        drop_d     = drop_q;
        abort_d    = abort_q;
        cmd_d      = cmd_q;
        val_d      = val_q;
        stat_d     = stat_q;
        sseq_d     = sseq_q;
        chk_d      = chk_q;
        last_grant = 1'b0;

        if (trig && busy_q && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (trig) begin
                    cmd_d   = trig_cmd;
                    val_d   = trig_val;
                    stat_d  = status;
                    sseq_d  = seq_q;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    req_d   = 1'b1;
                    dat_d   = swap16(SYNC_WORD);
                    state_d = ARM;
                end
            end

            ARM, SEND: begin
                // Checksum lands long before word 6 can be presented.
                if (state_q == ARM) begin
                    chk_d   = ~(SYNC_WORD + cmd_q + val_q[31:16] + val_q[15:0] + stat_q + sseq_q);
                    state_d = SEND;
                end
                if (up.up_grant) begin
                    if (idx_q == LAST_IDX) begin
                        last_grant = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                if (up.up_fin) begin
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    dat_d   = 16'h0000;
                    idx_d   = '0;
                    seq_d   = seq_q + 16'd1;
                    state_d = IDLE;
                    if (!last_grant && (abort_q != 8'hFF)) begin
                        abort_d = abort_q + 8'd1;
                    end
                end else if (last_grant) begin
                    dat_d   = 16'h0000;
                    state_d = WAIT_FIN;
                end else begin
                    dat_d = swap16(pkt_word(idx_d, cmd_q, val_q, stat_q, sseq_q, chk_q));
                end
            end

            WAIT_FIN: begin
                if (up.up_fin) begin
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    idx_d   = '0;
                    seq_d   = seq_q + 16'd1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = busy_q;
    assign seq       = seq_q;
    assign drop_cnt  = drop_q;
    assign abort_cnt = abort_q;
    assign up.up_req = req_q;
    assign up.up_dat = dat_q;

endmodule

// File: tb/tb_usb_resp_tx.sv
// Bench for usb_resp_tx: scoreboard of expected bus words built from a reference model.
module tb_usb_resp_tx;

    localparam int unsigned PKT = 256;
    localparam int unsigned BUDGET = 5000;

    logic        clk_24m;
    logic        rst_n;
    logic        trig;
    logic [15:0] trig_cmd;
    logic [31:0] trig_val;
    logic [15:0] status;
    logic        busy;
    logic [15:0] seq;
    logic [7:0]  drop_cnt;
    logic [7:0]  abort_cnt;

    usb_resp_tx_if up_if ();

    usb_resp_tx #(.PKT_WORDS(PKT), .SYNC_WORD(16'hA55A)) dut (
        .clk_24m   (clk_24m),
        .rst_n     (rst_n),
        .trig      (trig),
        .trig_cmd  (trig_cmd),
        .trig_val  (trig_val),
        .status    (status),
        .busy      (busy),
        .seq       (seq),
        .drop_cnt  (drop_cnt),
        .abort_cnt (abort_cnt),
        .up        (up_if)
    );

    initial clk_24m = 1'b0;
    always #5 clk_24m = ~clk_24m;

    int          n_checks;
    int          n_errors;
    logic [15:0] exp_q[$];
    logic [15:0] m_seq;
    logic [7:0]  m_drop;
    logic [7:0]  m_abort;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_24m);
        #1;
    endtask

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Reference packet: header, checksum, zero tail, then byte swap.
    function automatic void push_packet(input logic [15:0] c, input logic [31:0] v,
                                        input logic [15:0] s, input logic [15:0] sq);
        logic [15:0] w[7];
        logic [15:0] acc;
        logic [15:0] word;
        w[0] = 16'hA55A;
        w[1] = c;
        w[2] = v[31:16];
        w[3] = v[15:0];
        w[4] = s;
        w[5] = sq;
        acc  = 16'h0000;
        for (int i = 0; i < 6; i++) acc = acc + w[i];
        w[6] = ~acc;
        for (int i = 0; i < int'(PKT); i++) begin
            word = (i < 7) ? w[i] : 16'h0000;
            exp_q.push_back({word[7:0], word[15:8]});
        end
    endfunction

    task automatic check_counters(input string tag);
        check({tag, "_seq"}, 32'(seq), 32'(m_seq));
        check({tag, "_drop"}, 32'(drop_cnt), 32'(m_drop));
        check({tag, "_abort"}, 32'(abort_cnt), 32'(m_abort));
    endtask

    // One packet. mode 0: grant every cycle; mode 1: every third cycle with random gaps.
    // abort_at/rst_at >= 0 cut the packet after that many grants.
    task automatic run_packet(input logic [15:0] c, input logic [31:0] v, input logic [15:0] s,
                              input int mode, input int n_drop, input int abort_at,
                              input int rst_at, input bit fin_on_last, input bit trig_on_fin);
        int granted;
        int cyc;
        int drops;
        int target;
        bit g;
        push_packet(c, v, s, m_seq);
        trig     = 1'b1;
        trig_cmd = c;
        trig_val = v;
        status   = s;
        step();
        trig = 1'b0;
        check("req_latency", 32'(up_if.up_req), 32'd1);
        check("busy_on", 32'(busy), 32'd1);

        target  = (abort_at >= 0) ? abort_at : ((rst_at >= 0) ? rst_at : int'(PKT));
        granted = 0;
        cyc     = 0;
        drops   = 0;
        while (granted < target && cyc < int'(BUDGET)) begin
            g = (mode == 0) ? 1'b1 : ((cyc % 3 == 0) && ($urandom_range(0, 3) != 0));
            if (drops < n_drop && (cyc % 2 == 1)) begin
                trig     = 1'b1;
                trig_cmd = ~c;
                trig_val = ~v;
                status   = ~s;
                drops++;
                m_drop = sat_inc(m_drop);
            end
            if (g) begin
                if (exp_q.size() > 0) check("word", 32'(up_if.up_dat), 32'(exp_q.pop_front()));
                else check("sb_empty", 32'(exp_q.size()), 32'd1);
                up_if.up_grant = 1'b1;
                if (fin_on_last && granted == int'(PKT) - 1) up_if.up_fin = 1'b1;
                granted++;
            end else begin
                check("req_hold", 32'(up_if.up_req), 32'd1);
            end
            step();
            up_if.up_grant = 1'b0;
            up_if.up_fin   = 1'b0;
            trig           = 1'b0;
            cyc++;
        end
        check("grant_budget", 32'(granted), 32'(target));

        if (rst_at >= 0) begin
            #2;
            rst_n = 1'b0;
            #1;
            check("rst_req", 32'(up_if.up_req), 32'd0);
            check("rst_dat", 32'(up_if.up_dat), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            m_seq   = 16'h0000;
            m_drop  = 8'h00;
            m_abort = 8'h00;
            check_counters("rst");
            exp_q.delete();
            step();
            rst_n = 1'b1;
            step();
        end else if (abort_at >= 0) begin
            up_if.up_fin = 1'b1;
            step();
            up_if.up_fin = 1'b0;
            m_abort = sat_inc(m_abort);
            m_seq   = m_seq + 16'd1;
            exp_q.delete();
            check("abort_req", 32'(up_if.up_req), 32'd0);
            check("abort_busy", 32'(busy), 32'd0);
            check_counters("abort");
        end else begin
            if (!fin_on_last) begin
                check("wait_req", 32'(up_if.up_req), 32'd1);
                check("wait_dat", 32'(up_if.up_dat), 32'd0);
                up_if.up_grant = 1'b1;
                step();
                up_if.up_grant = 1'b0;
                check("wait_stray_dat", 32'(up_if.up_dat), 32'd0);
                check("wait_busy", 32'(busy), 32'd1);
                up_if.up_fin = 1'b1;
                if (trig_on_fin) begin
                    trig     = 1'b1;
                    trig_cmd = 16'hDEAD;
                    m_drop   = sat_inc(m_drop);
                end
                step();
                up_if.up_fin = 1'b0;
                trig         = 1'b0;
            end
            m_seq = m_seq + 16'd1;
            check("fin_req", 32'(up_if.up_req), 32'd0);
            check("fin_busy", 32'(busy), 32'd0);
            check("sb_drained", 32'(exp_q.size()), 32'd0);
            check_counters("fin");
            if (trig_on_fin) begin
                step();
                check("fin_trig_ignored", 32'(up_if.up_req), 32'd0);
            end
        end
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        m_seq          = 16'h0000;
        m_drop         = 8'h00;
        m_abort        = 8'h00;
        rst_n          = 1'b0;
        trig           = 1'b0;
        trig_cmd       = 16'h0000;
        trig_val       = 32'h0;
        status         = 16'h0000;
        up_if.up_grant = 1'b0;
        up_if.up_fin   = 1'b0;
        #1;
        check("reset_req", 32'(up_if.up_req), 32'd0);
        check("reset_dat", 32'(up_if.up_dat), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check_counters("reset");
        step();
        step();
        rst_n = 1'b1;
        step();

        // Basic frame, then stray grant in WAIT_FIN before fin.
        run_packet(16'h0002, 32'h01234567, 16'h00FF, 0, 0, -1, -1, 1'b0, 1'b0);
        // Throttled grants with three busy triggers.
        run_packet(16'h1234, 32'hCAFEF00D, 16'h8001, 1, 3, -1, -1, 1'b0, 1'b0);
        // Early fin after 10 grants, then a fresh packet.
        run_packet(16'h0BAD, 32'h89ABCDEF, 16'h0F0F, 0, 0, 10, -1, 1'b0, 1'b0);
        run_packet(16'h00A0, 32'hFFFFFFFF, 16'hFFFF, 0, 0, -1, -1, 1'b0, 1'b0);
        // Last grant coincident with fin.
        run_packet(16'h7E57, 32'h00000001, 16'h0001, 1, 0, -1, -1, 1'b1, 1'b0);
        // Trigger arriving with the completing fin is dropped.
        run_packet(16'h5555, 32'h12345678, 16'hAAAA, 0, 0, -1, -1, 1'b0, 1'b1);

        // Grants while idle must not disturb the next packet.
        for (int i = 0; i < 4; i++) begin
            up_if.up_grant = 1'b1;
            step();
        end
        up_if.up_grant = 1'b0;
        check("idle_grant_req", 32'(up_if.up_req), 32'd0);

        // Abort in ARM repeatedly: abort_cnt saturates at 255.
        for (int i = 0; i < 300; i++) begin
            trig     = 1'b1;
            trig_cmd = 16'(i);
            step();
            trig         = 1'b0;
            up_if.up_fin = 1'b1;
            step();
            up_if.up_fin = 1'b0;
            m_abort      = sat_inc(m_abort);
            m_seq        = m_seq + 16'd1;
        end
        check("abort_sat_busy", 32'(busy), 32'd0);
        check_counters("abort_sat");

        // Busy triggers saturate drop_cnt at 255; packet must be unaffected.
        run_packet(16'h0C0C, 32'h0BADBEEF, 16'h1357, 1, 300, -1, -1, 1'b0, 1'b0);
        // Reset at word 100, then a clean packet from zeroed state.
        run_packet(16'h4242, 32'h76543210, 16'h2468, 0, 0, -1, 100, 1'b0, 1'b0);
        run_packet(16'h0002, 32'h01234567, 16'h00FF, 1, 0, -1, -1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
